// File: rtl/morse_message_sequencer.sv
// Morse message sequencer: buffers up to DEPTH letter codes, then plays them
// back one at a time to a Morse encoder with GAP_CYCLES idle clocks between
// letters.
// Optional feature macro: MORSE_SEQ_REPEAT_EN -- loop the message until abort.
module morse_message_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 150000000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [2:0]               letter_in,
  input  logic                     start_msg,
  input  logic                     abort,
  input  logic                     enc_done,
  output logic [2:0]               enc_letter,
  output logic                     enc_start,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     busy,
  output logic                     msg_done
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] rd_idx;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    msg_buf [DEPTH];

  logic do_push;
  logic do_start;
  logic done_evt;
  logic last;
  logic gap_zero;

  assign do_push   = (state == IDLE) && push && !full && !start_msg && !abort;
  assign do_start  = (state == IDLE) && start_msg && (count != '0) && !abort;
  assign done_evt  = (state == WAIT_DONE) && enc_done && !abort;
  assign last      = ({1'b0, rd_idx} + CW'(1)) == count;
  assign gap_zero  = (gap_cnt == '0);

  assign enc_start = (state == ISSUE) && !abort;
  assign msg_done  = done_evt && last;
  assign busy      = (state != IDLE);
  assign full      = (count == DEPTH_C);

  // Next-state decode; abort overrides every other event
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (do_start) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (done_evt) begin
`ifdef MORSE_SEQ_REPEAT_EN
          state_nxt = GAP;
`else
          state_nxt = last ? IDLE : GAP;
`endif
        end
      end
      GAP:       if (gap_zero) state_nxt = ISSUE;
      default:   state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Letter count: grows on accepted pushes, cleared by abort or end of message
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     count <= '0;
    else if (abort)   count <= '0;
    else if (do_push) count <= count + CW'(1);
`ifndef MORSE_SEQ_REPEAT_EN
    else if (done_evt && last) count <= '0;
`endif
  end

  // Read index: held at 0 in IDLE, advances on each completed letter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                      rd_idx <= '0;
    else if (abort || state == IDLE)   rd_idx <= '0;
    else if (done_evt)                 rd_idx <= last ? '0 : rd_idx + IW'(1);
  end

  // Inter-letter gap counter: loaded on enc_done, counts down to 0 in GAP
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        gap_cnt <= '0;
    else if (abort)                      gap_cnt <= '0;
    else if (done_evt)                   gap_cnt <= GAP_LOAD;
    else if (state == GAP && !gap_zero)  gap_cnt <= gap_cnt - GW'(1);
  end

  // Letter presented to the encoder, latched on entry to ISSUE so it is
  // stable for the whole ISSUE/WAIT_DONE span
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                 enc_letter <= '0;
    else if (do_start)                            enc_letter <= msg_buf[0];
    else if (state == GAP && gap_zero && !abort)  enc_letter <= msg_buf[rd_idx];
  end

  // Message storage (not reset; only readable while count > 0)
  always_ff @(posedge clock) begin
    if (do_push) msg_buf[count[IW-1:0]] <= letter_in;
  end

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Directed self-checking bench for morse_message_sequencer (DEPTH=8,
// GAP_CYCLES=4). Define MORSE_SEQ_REPEAT_EN for both files to exercise looping.
module tb_morse_message_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       push;
  logic [2:0] letter_in;
  logic       start_msg;
  logic       abort;
  logic       enc_done;
  logic [2:0] enc_letter;
  logic       enc_start;
  logic [3:0] count;
  logic       full;
  logic       busy;
  logic       msg_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int starts_seen = 0;
  int dones_seen = 0;

  morse_message_sequencer #(.DEPTH(8), .GAP_CYCLES(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .letter_in  (letter_in),
    .start_msg  (start_msg),
    .abort      (abort),
    .enc_done   (enc_done),
    .enc_letter (enc_letter),
    .enc_start  (enc_start),
    .count      (count),
    .full       (full),
    .busy       (busy),
    .msg_done   (msg_done)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle
  always @(negedge clock) begin
    if (enc_start) starts_seen++;
    if (msg_done)  dones_seen++;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push_letter(input logic [2:0] v);
    push = 1'b1;
    letter_in = v;
    tick();
    push = 1'b0;
  endtask

  task automatic wait_start(output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (enc_start) begin
        ok = 1'b1;
        at = cyc;
      end else begin
        tick();
      end
    end
    if (!ok) check("enc_start_timeout", 0, 1);
  endtask

  logic [2:0] exp_msg [3];
  int at;
  int done_at;
  int s0;
  int d0;

  initial begin
    exp_msg = '{3'd1, 3'd2, 3'd7};
    reset_n = 1'b0; push = 1'b0; letter_in = '0; start_msg = 1'b0;
    abort = 1'b0; enc_done = 1'b0;
    #12;
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_enc_start", enc_start, 0);
    check("rst_enc_letter", enc_letter, 0);
    check("rst_msg_done", msg_done, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Fill to capacity, then one more
    for (int i = 0; i < 8; i++) push_letter(3'(i));
    check("full_after_8", full, 1);
    check("count_after_8", count, 8);
    push_letter(3'd5);
    check("count_9th_dropped", count, 8);

    // Abort in IDLE clears, and drops a same-cycle push
    abort = 1'b1; push = 1'b1; letter_in = 3'd3;
    tick();
    abort = 1'b0; push = 1'b0;
    check("idle_abort_count", count, 0);
    check("idle_abort_full", full, 0);

    // start with empty buffer is ignored; push together with start is dropped
    start_msg = 1'b1;
    tick();
    check("start_empty_busy", busy, 0);
    push = 1'b1; letter_in = 3'd6;
    tick();
    push = 1'b0; start_msg = 1'b0;
    check("push_start_empty_count", count, 0);
    check("push_start_empty_busy", busy, 0);

    // With one letter buffered, push+start starts playback and drops the push
    push_letter(3'd6);
    push = 1'b1; letter_in = 3'd2; start_msg = 1'b1;
    tick();
    push = 1'b0; start_msg = 1'b0;
    check("push_start_count", count, 1);
    check("push_start_enc_start", enc_start, 1);
    check("push_start_letter", enc_letter, 6);
    abort = 1'b1;
    #1;
    check("abort_issue_no_start", enc_start, 0);
    tick();
    abort = 1'b0;
    check("abort_issue_busy", busy, 0);
    check("abort_issue_count", count, 0);

`ifndef MORSE_SEQ_REPEAT_EN
    // Three-letter message with gap timing
    s0 = starts_seen; d0 = dones_seen; done_at = 0;
    push_letter(3'd1); push_letter(3'd2); push_letter(3'd7);
    check("msg_count", count, 3);
    start_msg = 1'b1;
    tick();
    start_msg = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_start(at);
      if (k > 0) check("gap_timing", at - done_at, 5);
      check("issue_letter", enc_letter, exp_msg[k]);
      tick(); tick();
      check("hold_letter", enc_letter, exp_msg[k]);
      check("wait_busy", busy, 1);
      enc_done = 1'b1;
      done_at = cyc;
      #1;
      check("msg_done_pulse", msg_done, (k == 2) ? 1 : 0);
      tick();
      enc_done = 1'b0;
    end
    check("msg_end_count", count, 0);
    check("msg_end_busy", busy, 0);
    tick();
    check("msg_start_total", starts_seen - s0, 3);
    check("msg_done_total", dones_seen - d0, 1);

    // Abort during WAIT_DONE of letter 2
    s0 = starts_seen; d0 = dones_seen;
    push_letter(3'd4); push_letter(3'd5); push_letter(3'd6);
    start_msg = 1'b1;
    tick();
    start_msg = 1'b0;
    wait_start(at);
    tick();
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
    wait_start(at);
    check("abort_l2_letter", enc_letter, 5);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_wd_busy", busy, 0);
    check("abort_wd_count", count, 0);
    repeat (10) tick();
    check("abort_wd_starts", starts_seen - s0, 2);
    check("abort_wd_dones", dones_seen - d0, 0);
`else
    // Two-letter message loops until abort
    d0 = dones_seen;
    push_letter(3'd3); push_letter(3'd5);
    start_msg = 1'b1;
    tick();
    start_msg = 1'b0;
    for (int it = 0; it < 6; it++) begin
      wait_start(at);
      check("rep_letter", enc_letter, (it % 2 == 0) ? 3 : 5);
      tick();
      enc_done = 1'b1;
      #1;
      check("rep_msg_done", msg_done, (it % 2 == 1) ? 1 : 0);
      check("rep_count", count, 2);
      tick();
      enc_done = 1'b0;
    end
    check("rep_busy_looping", busy, 1);
    check("rep_done_total", dones_seen - d0, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("rep_abort_busy", busy, 0);
    check("rep_abort_count", count, 0);
`endif

    // Asynchronous reset mid-playback discards the message
    push_letter(3'd2); push_letter(3'd3);
    start_msg = 1'b1;
    tick();
    start_msg = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_count", count, 0);
    check("async_rst_letter", enc_letter, 0);
    tick();
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/morse_message_sequencer.md
MORSE_MESSAGE_SEQUENCER -- requirements
Module: morse_message_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: message buffer capacity in letters; power of two, 2..16.
REQ-002 Parameter GAP_CYCLES, default 150000000: idle clocks inserted between consecutive letters; minimum 1.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 push  input  1  write letter_in into the buffer this cycle.
REQ-006 letter_in  input  3  letter code to store; 000=S through 111=Z.
REQ-007 start_msg  input  1  begin playback of the buffered message.
REQ-008 abort  input  1  stop playback and clear the buffer.
REQ-009 enc_done  input  1  one-cycle pulse from the encoder when the current letter has finished.
REQ-010 enc_letter  output  3  letter code presented to the encoder; held stable from issue until enc_done.
REQ-011 enc_start  output  1  one-cycle pulse requesting encoding of enc_letter.
REQ-012 count  output  $clog2(DEPTH)+1  number of letters currently buffered.
REQ-013 full  output  1  count == DEPTH.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 msg_done  output  1  one-cycle pulse when the last letter's enc_done is received.

Function
REQ-016 States: IDLE, ISSUE, WAIT_DONE, GAP; state register is binary-encoded with one always block per register group.
REQ-017 IDLE: push with !full and !start_msg writes letter_in at index count and increments count next cycle.
REQ-018 Push is dropped when full, when the state is not IDLE, or when start_msg is asserted in the same cycle.
REQ-019 IDLE with start_msg and count>0: read index rd_idx is set to 0 and the next state is ISSUE; start_msg with count==0 is ignored.
REQ-020 ISSUE lasts exactly one cycle: enc_start=1, enc_letter=buf[rd_idx], and the next state is WAIT_DONE.
REQ-021 WAIT_DONE holds enc_letter until enc_done=1; enc_done seen in any other state is ignored.
REQ-022 On enc_done with rd_idx<count-1: rd_idx increments and the state goes to GAP with the gap counter loaded to GAP_CYCLES-1.
REQ-023 GAP decrements the counter every cycle; at 0 the next state is ISSUE. enc_start therefore rises exactly GAP_CYCLES+1 cycles after enc_done.
REQ-024 On enc_done with rd_idx==count-1: msg_done pulses in the same cycle, count is cleared to 0, and the next state is IDLE (repeat behaviour: see REQ-031).
REQ-025 abort in any non-IDLE state takes priority over every other event: next state is IDLE, count=0, rd_idx=0, and no enc_start or msg_done is generated.
REQ-026 abort in IDLE clears count and drops any push in the same cycle.
REQ-027 start_msg while busy is ignored.
REQ-028 Gap counter width is $clog2(GAP_CYCLES+1) and the counter never wraps; rd_idx wraps only through reset or a return to IDLE.

Reset
REQ-029 reset_n=0 asynchronously forces: state=IDLE, count=0, rd_idx=0, gap counter=0, enc_start=0, enc_letter=000, msg_done=0, busy=0, full=0.
REQ-030 Buffer contents are not reset; they are unreadable while count==0, and reset mid-playback discards the message.

Configuration
REQ-031 Macro MORSE_SEQ_REPEAT_EN: when defined, the final enc_done goes to GAP with rd_idx=0 and count retained, msg_done still pulses, and playback loops until abort; when undefined, REQ-024 applies unchanged.

Verification
REQ-032 Reset, then push 001,010,111, then start_msg -> enc_start 3 times with enc_letter 001,010,111; msg_done once; count=0 afterwards.
REQ-033 GAP_CYCLES=4, enc_done at cycle N -> next enc_start at cycle N+5 exactly.
REQ-034 DEPTH=8, push 9 letters in IDLE -> full=1 after the 8th; the 9th is dropped and count stays 8.
REQ-035 Issue a 3-letter message, assert abort during WAIT_DONE of letter 2 -> busy=0 next cycle, count=0, no further enc_start, no msg_done.
REQ-036 start_msg with count=0 -> stays IDLE; push and start_msg in the same cycle -> push dropped.
REQ-037 With MORSE_SEQ_REPEAT_EN defined, a 2-letter message -> enc_letter sequence A,B,A,B... and msg_done after each B, until abort.
